// File: rtl/plc_ton_bank.sv
// plc_ton_bank: bank of CH start/stop latches, each with an on-delay timer.
// Optional off-delay behaviour is enabled by defining PLC_TOF_EN. Rev 1.0.
`default_nettype none

module plc_ton_bank #(
  parameter int CH      = 4,
  parameter int TW      = 16,
  parameter int OFF_DLY = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   start,
  input  logic [CH-1:0]   stop,
  input  logic            auto_mode,
  input  logic            man_mode,
  input  logic [CH*TW-1:0] preset,
  output logic [CH-1:0]   control,
  output logic [CH-1:0]   q,
  output logic [CH-1:0]   busy,
  output logic            fault
);

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_MAN  = 2'b01;
  localparam logic [1:0] M_AUTO = 2'b10;
  localparam logic [1:0] M_CONF = 2'b11;

`ifdef PLC_TOF_EN
  typedef enum logic [1:0] {IDLE, TIMING, ON, OFFDLY} state_t;
  localparam logic [TW-1:0] OFF_END = TW'(OFF_DLY);
`else
  typedef enum logic [1:0] {IDLE, TIMING, ON} state_t;
`endif

  if (CH < 1 || CH > 16 || TW < 1 || OFF_DLY < 1) begin : g_param_check
    $error("plc_ton_bank: parameter out of range");
  end

  state_t          st  [CH];
  logic [TW-1:0]   cnt [CH];
  logic [TW-1:0]   pre [CH];
  logic [1:0]      mode_q;
  logic [1:0]      mode_now;
  logic            mode_chg;

  // {auto,man} maps directly onto the mode codes above.
  assign mode_now = {auto_mode, man_mode};
  assign mode_chg = (mode_now != mode_q);

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= M_OFF;
      fault   <= 1'b0;
      control <= '0;
      q       <= '0;
      busy    <= '0;
      for (int i = 0; i < CH; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
        pre[i] <= '0;
      end
    end else begin
      mode_q <= mode_now;
      fault  <= (mode_now == M_CONF);
      for (int i = 0; i < CH; i++) begin
        if (mode_chg || mode_now == M_OFF || mode_now == M_CONF) begin
          st[i]      <= IDLE;
          cnt[i]     <= '0;
          control[i] <= 1'b0;
          q[i]       <= 1'b0;
          busy[i]    <= 1'b0;
        end else if (mode_now == M_MAN) begin
          st[i]      <= IDLE;
          cnt[i]     <= '0;
          control[i] <= start[i] & ~stop[i];
          q[i]       <= start[i] & ~stop[i];
          busy[i]    <= 1'b0;
        end else begin
          case (st[i])
            IDLE: begin
              cnt[i] <= '0;
              if (start[i] && !stop[i]) begin
                pre[i]     <= preset[i*TW +: TW];
                control[i] <= 1'b1;
                if (preset[i*TW +: TW] == '0) begin
                  st[i]   <= ON;
                  q[i]    <= 1'b1;
                  busy[i] <= 1'b0;
                end else begin
                  st[i]   <= TIMING;
                  q[i]    <= 1'b0;
                  busy[i] <= 1'b1;
                end
              end else begin
                control[i] <= 1'b0;
                q[i]       <= 1'b0;
                busy[i]    <= 1'b0;
              end
            end
            TIMING: begin
              if (stop[i]) begin
                st[i]      <= IDLE;
                cnt[i]     <= '0;
                control[i] <= 1'b0;
                q[i]       <= 1'b0;
                busy[i]    <= 1'b0;
              end else begin
                cnt[i] <= sat_inc(cnt[i]);
                if (sat_inc(cnt[i]) == pre[i]) begin
                  st[i]   <= ON;
                  q[i]    <= 1'b1;
                  busy[i] <= 1'b0;
                end
              end
            end
            ON: begin
              if (stop[i]) begin
                cnt[i]     <= '0;
                control[i] <= 1'b0;
`ifdef PLC_TOF_EN
                // q stays high through the off-delay window.
                st[i]      <= OFFDLY;
                busy[i]    <= 1'b1;
`else
                st[i]      <= IDLE;
                q[i]       <= 1'b0;
                busy[i]    <= 1'b0;
`endif
              end
            end
`ifdef PLC_TOF_EN
            OFFDLY: begin
              if (start[i] && !stop[i]) begin
                st[i]      <= ON;
                cnt[i]     <= pre[i];
                control[i] <= 1'b1;
                busy[i]    <= 1'b0;
              end else begin
                cnt[i] <= sat_inc(cnt[i]);
                if (sat_inc(cnt[i]) == OFF_END) begin
                  st[i]   <= IDLE;
                  cnt[i]  <= '0;
                  q[i]    <= 1'b0;
                  busy[i] <= 1'b0;
                end
              end
            end
`endif
            default: begin
              st[i]      <= IDLE;
              cnt[i]     <= '0;
              control[i] <= 1'b0;
              q[i]       <= 1'b0;
              busy[i]    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire
